// File: rtl/uart_pkg.sv
// Shared UART constants: FSM state encoding and oversampling sample points.
package uart_pkg;

   localparam int OS_DEFAULT = 16;

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] START     = 3'd1;
   localparam logic [2:0] DATA      = 3'd2;
   localparam logic [2:0] STOP      = 3'd3;
   localparam logic [2:0] WAIT_HIGH = 3'd4;

   // The three samples straddle mid-bit and end on the bit's last tick.
   function automatic int samp0(input int os);
      return os - 3;
   endfunction

   function automatic int samp1(input int os);
      return os - 2;
   endfunction

   function automatic int samp2(input int os);
      return os - 1;
   endfunction

   function automatic int mid_start(input int os);
      return os / 2 - 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset level.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = i_d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign o_q = sync_q;

endmodule

// File: rtl/uart_rx_os16.sv
// UART receiver with OS-times oversampling, 3-sample majority vote per bit and
// a separate framing-error pulse; a low stop bit parks the FSM until the line idles.
module uart_rx_os16
   import uart_pkg::*;
#(
   parameter int N  = 8,
   parameter int OS = OS_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_tick,
   input  logic         i_rx,
   output logic [N-1:0] o_data,
   output logic         o_valid,
   output logic         o_frame_err,
   output logic         o_busy
);

   localparam int SW = $clog2(OS);
   localparam int NW = $clog2(N) + 1;

   localparam logic [SW-1:0] S_SAMP0 = SW'(samp0(OS));
   localparam logic [SW-1:0] S_SAMP1 = SW'(samp1(OS));
   localparam logic [SW-1:0] S_SAMP2 = SW'(samp2(OS));
   localparam logic [SW-1:0] S_MID   = SW'(mid_start(OS));
   localparam logic [NW-1:0] N_LAST  = NW'(N - 1);

   logic          rx_s;
   logic [2:0]    state_q, state_d;
   logic [SW-1:0] s_q, s_d;
   logic [NW-1:0] n_q, n_d;
   logic [N-1:0]  sh_q, sh_d;
   logic [1:0]    samp_q, samp_d;
   logic [N-1:0]  data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          maj;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .reset (reset),
      .i_d   (i_rx),
      .o_q   (rx_s)
   );

   // Third sample is the live rx_s on the bit's last tick.
   assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      sh_d    = sh_q;
      samp_d  = samp_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               s_d     = '0;
            end
         end
         START: begin
            if (i_tick) begin
               if (s_q == S_MID) begin
                  s_d     = '0;
                  n_d     = '0;
                  state_d = rx_s ? IDLE : DATA;
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         DATA, STOP: begin
            if (i_tick) begin
               s_d = s_q + 1'b1;
               if (s_q == S_SAMP0) samp_d[0] = rx_s;
               if (s_q == S_SAMP1) samp_d[1] = rx_s;
               if (s_q == S_SAMP2) begin
                  s_d = '0;
                  if (state_q == DATA) begin
                     sh_d = {maj, sh_q[N-1:1]};
                     n_d  = n_q + 1'b1;
                     if (n_q == N_LAST) state_d = STOP;
                  end else if (maj) begin
                     data_d  = sh_q;
                     valid_d = 1'b1;
                     state_d = IDLE;
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = WAIT_HIGH;
                  end
               end
            end
         end
         WAIT_HIGH: begin
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         sh_q    <= '0;
         samp_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         sh_q    <= sh_d;
         samp_q  <= samp_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign o_data      = data_q;
   assign o_valid     = valid_q;
   assign o_frame_err = ferr_q;
   assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: directed frame table, hand-written corner sequences,
// and random frames checked against a frame-level expectation model.
module tb_uart_rx_os16;

   localparam int N  = 8;
   localparam int OS = 16;

   logic         clk   = 1'b0;
   logic         reset = 1'b1;
   logic         i_rx  = 1'b1;
   logic         i_tick;
   logic [N-1:0] o_data;
   logic         o_valid, o_frame_err, o_busy;
   logic [1:0]   tick_ph = 2'd0;

   int          n_cmp = 0;
   int          n_err = 0;
   int          ferr_cnt = 0;
   logic        prev_valid = 1'b0;
   logic [7:0]  vq[$];
   logic [7:0]  last_good;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         gbit;       // data bit carrying a one-sample glitch, -1 for none
      int         goff;       // tick interval within that bit (6..8 hit a sample)
      int         hold_low;   // extra bit times line stays low after a bad stop bit
      int         gap;        // idle-high bit times after the frame
      logic       exp_valid;
      logic       exp_ferr;
      logic [7:0] exp_odata;
   } vec_t;

   vec_t tbl[7];
   vec_t v;

   uart_rx_os16 #(.N(N), .OS(OS)) dut (
      .clk         (clk),
      .reset       (reset),
      .i_tick      (i_tick),
      .i_rx        (i_rx),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .o_frame_err (o_frame_err),
      .o_busy      (o_busy)
   );

   always #5 clk = ~clk;

   // One tick every 4 clk, so one bit is 64 clk.
   always @(posedge clk) tick_ph <= tick_ph + 2'd1;
   assign i_tick = (tick_ph == 2'd3);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (o_valid) vq.push_back(o_data);
         if (o_frame_err) ferr_cnt++;
         if (o_valid || o_frame_err) chk("valid_ferr_exclusive", {31'd0, o_valid & o_frame_err}, 32'd0);
         if (prev_valid) chk("busy_after_valid", {31'd0, o_busy}, 32'd0);
         prev_valid = o_valid;
      end else begin
         prev_valid = 1'b0;
      end
   end

   // Returns just after the clock edge that consumed k ticks.
   task automatic wait_ticks(input int k);
      for (int i = 0; i < k; i++) begin
         do begin
            @(posedge clk);
            #1;
         end while (tick_ph != 2'd0);
      end
   endtask

   task automatic send_bit(input logic lvl, input int goff);
      i_rx = lvl;
      if (goff == 0) begin
         wait_ticks(OS);
      end else begin
         wait_ticks(goff - 1);
         i_rx = ~lvl;
         wait_ticks(1);
         i_rx = lvl;
         wait_ticks(OS - goff);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input int gbit, input int goff);
      send_bit(1'b0, 0);
      for (int j = 0; j < N; j++) send_bit(d[j], (j == gbit) ? goff : 0);
      send_bit(stop, 0);
   endtask

   task automatic run_vec(input vec_t tv);
      int nv0;
      int nf0;
      nv0 = vq.size();
      nf0 = ferr_cnt;
      send_frame(tv.data, tv.stop, tv.gbit, tv.goff);
      if (tv.hold_low > 0) begin
         i_rx = 1'b0;
         wait_ticks(OS * tv.hold_low);
         chk("busy_while_line_low", {31'd0, o_busy}, 32'd1);
      end
      i_rx = 1'b1;
      wait_ticks(OS * tv.gap);
      chk("valid_count", 32'(vq.size() - nv0), {31'd0, tv.exp_valid});
      chk("ferr_count", 32'(ferr_cnt - nf0), {31'd0, tv.exp_ferr});
      if (tv.exp_valid && vq.size() > nv0) chk("valid_data", {24'd0, vq[nv0]}, {24'd0, tv.exp_odata});
      chk("o_data_held", {24'd0, o_data}, {24'd0, tv.exp_odata});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int nv0;
      int nf0;
      logic [7:0] c3;

      //                data   stop gbit goff hold gap  valid ferr odata
      tbl[0] = '{8'hA5, 1'b1, -1, 0,  0, 1, 1'b1, 1'b0, 8'hA5};
      tbl[1] = '{8'h3C, 1'b0, -1, 0, 20, 1, 1'b0, 1'b1, 8'hA5};
      tbl[2] = '{8'h11, 1'b1, -1, 0,  0, 1, 1'b1, 1'b0, 8'h11};
      tbl[3] = '{8'h01, 1'b1, -1, 0,  0, 0, 1'b1, 1'b0, 8'h01};
      tbl[4] = '{8'hFF, 1'b1, -1, 0,  0, 0, 1'b1, 1'b0, 8'hFF};
      tbl[5] = '{8'h00, 1'b1, -1, 0,  0, 1, 1'b1, 1'b0, 8'h00};
      tbl[6] = '{8'h5A, 1'b1,  3, 7,  0, 1, 1'b1, 1'b0, 8'h5A};

      reset = 1'b1;
      i_rx  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_o_data", {24'd0, o_data}, 32'd0);
      chk("reset_o_valid", {31'd0, o_valid}, 32'd0);
      chk("reset_o_frame_err", {31'd0, o_frame_err}, 32'd0);
      chk("reset_o_busy", {31'd0, o_busy}, 32'd0);
      reset = 1'b0;
      wait_ticks(OS);

      for (int k = 0; k < 7; k++) run_vec(tbl[k]);

      // False start: low for 3 ticks, decision lands on the 8th tick.
      nv0 = vq.size();
      nf0 = ferr_cnt;
      i_rx = 1'b0;
      wait_ticks(3);
      chk("false_start_busy", {31'd0, o_busy}, 32'd1);
      i_rx = 1'b1;
      wait_ticks(4);
      chk("false_start_busy_s7", {31'd0, o_busy}, 32'd1);
      wait_ticks(1);
      chk("false_start_idle", {31'd0, o_busy}, 32'd0);
      wait_ticks(OS);
      chk("false_start_no_valid", 32'(vq.size() - nv0), 32'd0);
      chk("false_start_no_ferr", 32'(ferr_cnt - nf0), 32'd0);

      // Reset in the middle of data bit 4, line released high at the same time.
      c3 = 8'hC3;
      nv0 = vq.size();
      send_bit(1'b0, 0);
      for (int j = 0; j < 4; j++) send_bit(c3[j], 0);
      i_rx = c3[4];
      wait_ticks(8);
      chk("mid_frame_busy", {31'd0, o_busy}, 32'd1);
      reset = 1'b1;
      i_rx  = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("midrst_o_data", {24'd0, o_data}, 32'd0);
      chk("midrst_o_valid", {31'd0, o_valid}, 32'd0);
      chk("midrst_o_frame_err", {31'd0, o_frame_err}, 32'd0);
      chk("midrst_o_busy", {31'd0, o_busy}, 32'd0);
      wait_ticks(OS);
      chk("midrst_no_partial", 32'(vq.size() - nv0), 32'd0);
      v = '{8'h5A, 1'b1, -1, 0, 0, 1, 1'b1, 1'b0, 8'h5A};
      run_vec(v);
      last_good = 8'h5A;

      // Random frames: a high stop bit delivers the byte, a low one only flags an error.
      for (int k = 0; k < 16; k++) begin
         v.data     = 8'($urandom_range(0, 255));
         v.stop     = ($urandom_range(0, 3) != 0);
         v.gbit     = int'($urandom_range(0, 8));
         if (v.gbit == 8) v.gbit = -1;
         v.goff     = int'($urandom_range(6, 8));
         v.hold_low = v.stop ? 0 : int'($urandom_range(0, 2));
         v.gap      = v.stop ? int'($urandom_range(0, 1)) : 1;
         v.exp_valid = v.stop;
         v.exp_ferr  = !v.stop;
         if (v.stop) last_good = v.data;
         v.exp_odata = last_good;
         run_vec(v);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
UART receive front end with 16x oversampling. It turns the serial line into N-bit bytes for the command interface stage, which collects operands A and B and the opcode for the ALU. It runs on the 16x-baud tick from the baud-rate generator. It applies a 2-FF synchronizer and 3-sample majority voting, and reports framing errors separately from valid bytes.

Parameters:
N, 8, data bits per frame (LSB first, no parity, 1 stop bit)
OS, 16, oversampling ticks per bit; OS must be a power of 2 and at least 8

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
i_tick  input  1  one-clk pulse at OS*BAUD_RATE, from the baud-rate generator
i_rx  input  1  asynchronous serial line, idle high
o_data  output  N  last good byte; held until the next good byte
o_valid  output  1  one-clk pulse: o_data is updated this cycle
o_frame_err  output  1  one-clk pulse: stop bit sampled low
o_busy  output  1  high while state != IDLE

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous, active-high `reset`.
- Reset values: o_data=0, o_valid=0, o_frame_err=0, o_busy=0, state=IDLE, synchronizer flops=1, all counters=0.
- Reset mid-frame: on the next edge the block is in IDLE with all outputs at reset values. No partial byte is emitted.
- Synchronizer: rx_s is i_rx after 2 flops. All decisions below use rx_s.
- Counters: s is the tick counter, log2(OS) bits. n is the bit counter, log2(N)+1 bits.
- Counter advance: s and n change only on cycles with i_tick=1. The FSM stays frozen while no ticks arrive.
- IDLE:
  - When rx_s==0: go to START with s=0. This does not wait for a tick.
- START:
  - On each tick, s++.
  - At s==OS/2-1 (mid start bit): if rx_s==0, go to DATA with s=0, n=0. Otherwise treat it as a false start and return to IDLE.
- DATA:
  - On each tick, s++.
  - Record rx_s at s==OS-3, OS-2 and OS-1 (straddling mid-bit).
  - At s==OS-1: shift the majority of the 3 samples into the MSB of the shift register (right shift, so LSB-first bits end up in place), set s=0, n++.
  - When n reaches N, go to STOP.
- STOP:
  - Same 3-sample majority as DATA.
  - At s==OS-1 with majority==1: o_data<=shift register, o_valid=1 for one clk, go to IDLE.
  - At s==OS-1 with majority==0: o_frame_err=1 for one clk, o_data unchanged, go to WAIT_HIGH.
- WAIT_HIGH (break/stuck-low guard): stay until rx_s==1, then go to IDLE. No new frame is detected while the line stays low.
- Latency: o_valid rises in the clk after the tick where s==OS-1 in STOP. This is half a bit period before the nominal end of the stop bit, which leaves time to catch a back-to-back start edge.
- Mutual exclusion: o_valid and o_frame_err are never high in the same cycle.
- Tick and start edge together: the IDLE→START transition takes priority. That tick is not counted, so s stays 0.
- Consumer contract: there is no backpressure. The consumer must take o_data on the o_valid pulse.

Decomposition:
- Package uart_pkg holds:
  - state encoding: IDLE, START, DATA, STOP, WAIT_HIGH (3 bits)
  - OS default
  - sample-point constants SAMP0=OS-3, SAMP1=OS-2, SAMP2=OS-1
  - MID_START=OS/2-1
- Sub-module sync_2ff (1-bit, reset value 1): reusable for any asynchronous input in the codebase.
- The majority vote is inline combinational logic.

Test Plan:
- Setup for all scenarios: i_tick pulses every 4 clk, so one bit = 64 clk.
- Good byte: frame 0xA5 with stop bit 1 → exactly one o_valid pulse, o_data=0xA5, o_frame_err never high, o_busy drops the cycle after o_valid.
- False start: i_rx low for 3 ticks then high → no o_valid and no o_frame_err. o_busy returns to 0 at s==7 of START.
- Framing error: first 0xA5 good, then 0x3C with stop bit 0, then line held low for 20 bit times → one o_frame_err pulse, o_data stays 0xA5, no o_valid. After the line goes high, the next frame 0x11 gives o_data=0x11.
- Back-to-back: 0x01, 0xFF, 0x00 with stop bits exactly 16 ticks and no idle gap → three o_valid pulses in order with the correct data and no frame errors.
- Noise: in frame 0x5A, force one of the 3 sample ticks of bit 3 to the wrong level → o_data=0x5A (majority recovers the bit).
- Reset mid-frame: assert reset for 1 clk during data bit 4 of 0xC3 → next cycle all outputs are 0 and o_busy=0. A following full frame 0x5A gives o_valid with o_data=0x5A.
